// File: rtl/scoped_import_fifo.sv
// Show-ahead synchronous FIFO with registered EMPTY/PARTIAL/FULL state and sticky overflow flag.
// Optional macro SCOPED_FIFO_OCC_EN adds the occ port (registered occupancy count).
package fifo_pkg;
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  localparam int FIFO_DEPTH_DFLT = 4;
  // Same name as the module parameter; the module must always resolve DEPTH locally.
  localparam int DEPTH = 16;
endpackage

module scoped_import_fifo
  import fifo_pkg::state_t;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH = fifo_pkg::FIFO_DEPTH_DFLT,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output state_t            state,
`ifdef SCOPED_FIFO_OCC_EN
  output logic              ovf,
  output logic [CNT_W-1:0]  occ
`else
  output logic              ovf
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  state_t            state_q, state_d;
  logic              ovf_q, ovf_d;
  logic              push_s, pop_s;

  assign wr_ready = (state_q != fifo_pkg::ST_FULL);
  assign rd_valid = (state_q != fifo_pkg::ST_EMPTY);
  assign push_s   = wr_valid & wr_ready;
  assign pop_s    = rd_valid & rd_ready;
  // Head is forced to zero while empty so stale memory never shows on rd_data.
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : {DATA_W{1'b0}};
  assign state    = state_q;
  assign ovf      = ovf_q;
`ifdef SCOPED_FIFO_OCC_EN
  assign occ      = count_q;
`endif

  // Pointer, count, overflow and FSM next-state logic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    ovf_d    = ovf_q | (wr_valid & ~wr_ready);

    if (push_s) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? {PTR_W{1'b0}} : wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? {PTR_W{1'b0}} : rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    case (state_q)
      fifo_pkg::ST_EMPTY: begin
        if (push_s) state_d = fifo_pkg::ST_PARTIAL;
        else        state_d = fifo_pkg::ST_EMPTY;
      end
      fifo_pkg::ST_PARTIAL: begin
        if (count_d == CNT_FULL)              state_d = fifo_pkg::ST_FULL;
        else if (count_d == {CNT_W{1'b0}})    state_d = fifo_pkg::ST_EMPTY;
        else                                  state_d = fifo_pkg::ST_PARTIAL;
      end
      fifo_pkg::ST_FULL: begin
        if (pop_s) state_d = fifo_pkg::ST_PARTIAL;
        else       state_d = fifo_pkg::ST_FULL;
      end
      default: state_d = fifo_pkg::ST_EMPTY;
    endcase
  end

  // Control registers; reset overrides any same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      state_q  <= fifo_pkg::ST_EMPTY;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_scoped_import_fifo.sv
// Randomised bench for scoped_import_fifo: a DEPTH=4 and a DEPTH=3 instance checked against queue models.
module tb_scoped_import_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       wv [2];
  logic       rr [2];
  logic [7:0] wd [2];

  logic       wrdy4, rval4, ovf4, wrdy3, rval3, ovf3;
  logic [7:0] rdat4, rdat3;
  fifo_pkg::state_t st4, st3;
`ifdef SCOPED_FIFO_OCC_EN
  logic [2:0] occ4;
  logic [1:0] occ3;
`endif

  scoped_import_fifo #(.DATA_W(8), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .wr_valid(wv[0]), .wr_ready(wrdy4), .wr_data(wd[0]),
    .rd_valid(rval4), .rd_ready(rr[0]), .rd_data(rdat4), .state(st4),
`ifdef SCOPED_FIFO_OCC_EN
    .ovf(ovf4), .occ(occ4)
`else
    .ovf(ovf4)
`endif
  );

  scoped_import_fifo #(.DATA_W(8), .DEPTH(3)) dut3 (
    .clk(clk), .rst(rst), .wr_valid(wv[1]), .wr_ready(wrdy3), .wr_data(wd[1]),
    .rd_valid(rval3), .rd_ready(rr[1]), .rd_data(rdat3), .state(st3),
`ifdef SCOPED_FIFO_OCC_EN
    .ovf(ovf3), .occ(occ3)
`else
    .ovf(ovf3)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference model: one queue of stored bytes and a sticky overflow bit per instance.
  logic [7:0] mq [2][$];
  logic       movf [2];
  int         dep [2] = '{4, 3};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      int n;
      fifo_pkg::state_t es;
      logic [7:0] ed;
      string p;
      n  = mq[i].size();
      es = (n == 0) ? fifo_pkg::ST_EMPTY : ((n == dep[i]) ? fifo_pkg::ST_FULL : fifo_pkg::ST_PARTIAL);
      ed = (n > 0) ? mq[i][0] : 8'h00;
      p  = $sformatf("d%0d_", dep[i]);
      chk({p, "state"},    32'((i == 0) ? st4 : st3), 32'(es));
      chk({p, "wr_ready"}, 32'((i == 0) ? wrdy4 : wrdy3), 32'(n < dep[i]));
      chk({p, "rd_valid"}, 32'((i == 0) ? rval4 : rval3), 32'(n > 0));
      chk({p, "rd_data"},  32'((i == 0) ? rdat4 : rdat3), 32'(ed));
      chk({p, "ovf"},      32'((i == 0) ? ovf4 : ovf3), 32'(movf[i]));
`ifdef SCOPED_FIFO_OCC_EN
      chk({p, "occ"},      (i == 0) ? 32'(occ4) : 32'(occ3), 32'(n));
`endif
    end
  endtask

  // Inputs are already set (at a negedge); advance the model and the DUTs one edge, then compare.
  task automatic cycle();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mq[i].delete();
        movf[i] = 1'b0;
      end else begin
        int  n;
        bit  push, pop;
        n = mq[i].size();
        if (wv[i] && n == dep[i]) movf[i] = 1'b1;
        push = wv[i] && (n < dep[i]);
        pop  = rr[i] && (n > 0);
        if (pop)  void'(mq[i].pop_front());
        if (push) mq[i].push_back(wd[i]);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input int i, input logic v, input logic r, input logic [7:0] d);
    wv[i] = v;
    rr[i] = r;
    wd[i] = d;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(i, 1'b0, 1'b0, 8'h00);
      movf[i] = 1'b0;
    end
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b0;

    // DEPTH=4: fill with A1..A4, then drain in order.
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b1, 1'b0, 8'(8'hA1 + k));
      cycle();
    end
    chk("d4_full_after_4", 32'(st4), 32'(fifo_pkg::ST_FULL));
    drive(0, 1'b0, 1'b1, 8'h00);
    for (int k = 0; k < 4; k++) cycle();
    chk("d4_empty_after_drain", 32'(st4), 32'(fifo_pkg::ST_EMPTY));
    drive(0, 1'b0, 1'b0, 8'h00);

    // DEPTH=3: seven single push/pop pairs force both pointers through the 2->0 wrap.
    for (int k = 0; k < 7; k++) begin
      drive(1, 1'b1, 1'b0, 8'(8'h30 + k));
      cycle();
      drive(1, 1'b0, 1'b1, 8'h00);
      cycle();
    end
    drive(1, 1'b0, 1'b0, 8'h00);
    chk("d3_no_ovf_wrap", 32'(ovf3), 32'd0);

    // Count 2, then simultaneous push and pop.
    drive(0, 1'b1, 1'b0, 8'h11); cycle();
    drive(0, 1'b1, 1'b0, 8'h22); cycle();
    drive(0, 1'b1, 1'b1, 8'h33); cycle();
    chk("d4_pushpop_partial", 32'(st4), 32'(fifo_pkg::ST_PARTIAL));

    // Fill, overflow attempt, then show ovf is sticky and contents untouched.
    drive(0, 1'b1, 1'b0, 8'h44); cycle();
    drive(0, 1'b1, 1'b0, 8'h55); cycle();
    drive(0, 1'b1, 1'b0, 8'hEE); cycle();
    chk("d4_ovf_set", 32'(ovf4), 32'd1);
    drive(0, 1'b0, 1'b1, 8'h00);
    for (int k = 0; k < 5; k++) cycle();
    chk("d4_ovf_sticky", 32'(ovf4), 32'd1);

    // Count 3, then reset with push and pop both requested.
    for (int k = 0; k < 3; k++) begin
      drive(0, 1'b1, 1'b0, 8'(8'h60 + k));
      cycle();
    end
    drive(0, 1'b1, 1'b1, 8'h77);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 8'h00);
    chk("d4_rst_empty", 32'(rval4), 32'd0);
    chk("d4_rst_ovf_clr", 32'(ovf4), 32'd0);
    cycle();

    // Random traffic on both instances with rare resets; bias flips between fill and drain phases.
    for (int k = 0; k < 600; k++) begin
      int bias;
      bias = ((k / 50) % 2 == 0) ? 3 : 1;
      for (int i = 0; i < 2; i++) begin
        drive(i, 1'($urandom_range(0, 3) < bias), 1'($urandom_range(0, 3) >= bias),
              8'($urandom));
      end
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
